// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and defaults for the FIFO read-port burst scheduler.
package fifo_rd_sched_pkg;

    localparam int unsigned BLEN_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    // Index width for a requester pointer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_sched_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after rr_ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output logic [PTR_W-1:0]   o_idx_c,
    output logic               o_any_c
);

    int unsigned w_idx;

    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        o_any_c = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = 32'(rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!o_any_c && req[PTR_W'(w_idx)]) begin
                o_any_c                  = 1'b1;
                o_idx_c                  = PTR_W'(w_idx);
                o_gnt_c[PTR_W'(w_idx)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Arbitrates one FIFO read port among NUM_REQ burst requesters and paces pops
// to the granted requester's ready, ending on burst length or request withdrawal.
module fifo_rd_sched
    import fifo_rd_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BLEN_W     = BLEN_W_DEF
) (
    input  logic                        r_Clk,
    input  logic                        r_Rst,
    input  logic                        fifo_Empty,
    input  logic [DATA_WIDTH-1:0]       fifo_Rdata,
    output logic                        r_Inc,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*BLEN_W-1:0]   req_Blen,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [DATA_WIDTH-1:0]       rd_Data,
    output logic                        rd_Valid,
    input  logic [NUM_REQ-1:0]          rd_Ready,
    output logic                        burst_Done,
    output logic                        burst_Abort
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);

    state_t               r_state,    w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt,      w_gnt_nxt;
    logic [PTR_W-1:0]     r_gidx,     w_gidx_nxt;
    logic [PTR_W-1:0]     r_rr_ptr,   w_rr_ptr_nxt;
    logic [BLEN_W-1:0]    r_blen,     w_blen_nxt;
    logic [BLEN_W-1:0]    r_beat_cnt, w_beat_cnt_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_abort,    w_abort_nxt;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [PTR_W-1:0]     w_arb_idx;
    logic                 w_arb_any;
    logic [BLEN_W-1:0]    w_sel_blen;
    logic                 w_req_g;
    logic                 w_rdy_g;
    logic [PTR_W-1:0]     w_ptr_inc;
    logic                 w_valid;
    logic                 w_inc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .o_gnt_c (w_arb_gnt),
        .o_idx_c (w_arb_idx),
        .o_any_c (w_arb_any)
    );

    // Burst length of the arbitration winner, captured only at grant.
    always_comb begin
        w_sel_blen = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_sel_blen = w_sel_blen | req_Blen[i*BLEN_W +: BLEN_W];
            end
        end
    end

    assign w_req_g   = |(req & r_gnt);
    assign w_rdy_g   = |(rd_Ready & r_gnt);
    assign w_ptr_inc = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);

    always_ff @(posedge r_Clk or negedge r_Rst) begin
        if (!r_Rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_rr_ptr   <= '0;
            r_blen     <= '0;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gidx     <= w_gidx_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_blen     <= w_blen_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_done     <= w_done_nxt;
            r_abort    <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gidx_nxt     = r_gidx;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_blen_nxt     = r_blen;
        w_beat_cnt_nxt = r_beat_cnt;
        w_done_nxt     = 1'b0;
        w_abort_nxt    = 1'b0;
        w_valid        = 1'b0;
        w_inc          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_state_nxt    = ST_GRANT;
                    w_gnt_nxt      = w_arb_gnt;
                    w_gidx_nxt     = w_arb_idx;
                    w_blen_nxt     = w_sel_blen;
                    w_beat_cnt_nxt = '0;
                end
            end

            ST_GRANT: begin
                w_state_nxt = ST_XFER;
            end

            ST_XFER: begin
                w_valid = ~fifo_Empty & w_req_g;
                w_inc   = w_valid & w_rdy_g;
                // A withdrawn request wins over a final beat: nothing pops, burst aborts.
                if (!w_req_g) begin
                    w_state_nxt  = ST_IDLE;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = w_ptr_inc;
                    w_done_nxt   = 1'b1;
                    w_abort_nxt  = 1'b1;
                end else if (w_inc) begin
                    w_beat_cnt_nxt = r_beat_cnt + BLEN_W'(1);
                    if (r_beat_cnt == r_blen) begin
                        w_state_nxt  = ST_IDLE;
                        w_gnt_nxt    = '0;
                        w_rr_ptr_nxt = w_ptr_inc;
                        w_done_nxt   = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    assign rd_Valid    = w_valid;
    assign r_Inc       = w_inc;
    assign rd_Data     = fifo_Rdata;
    assign gnt         = r_gnt;
    assign burst_Done  = r_done;
    assign burst_Abort = r_abort;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Randomized and directed bench for fifo_rd_sched against a transaction-level model.
module tb_fifo_rd_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BW = 2;

    logic              r_Clk;
    logic              r_Rst;
    logic              fifo_Empty;
    logic [DW-1:0]     fifo_Rdata;
    logic              r_Inc;
    logic [N-1:0]      req;
    logic [N*BW-1:0]   req_Blen;
    logic [N-1:0]      gnt;
    logic [DW-1:0]     rd_Data;
    logic              rd_Valid;
    logic [N-1:0]      rd_Ready;
    logic              burst_Done;
    logic              burst_Abort;

    fifo_rd_sched #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BLEN_W     (BW)
    ) dut (
        .r_Clk       (r_Clk),
        .r_Rst       (r_Rst),
        .fifo_Empty  (fifo_Empty),
        .fifo_Rdata  (fifo_Rdata),
        .r_Inc       (r_Inc),
        .req         (req),
        .req_Blen    (req_Blen),
        .gnt         (gnt),
        .rd_Data     (rd_Data),
        .rd_Valid    (rd_Valid),
        .rd_Ready    (rd_Ready),
        .burst_Done  (burst_Done),
        .burst_Abort (burst_Abort)
    );

    initial r_Clk = 1'b0;
    always #5 r_Clk = ~r_Clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model: owner of the port (-1 none), whether it is in its dead grant cycle,
    // beats still owed, next search start, and the pulse due this cycle.
    int m_owner = -1;
    bit m_fresh = 1'b0;
    int m_left  = 0;
    int m_ptr   = 0;
    bit m_done  = 1'b0;
    bit m_abort = 1'b0;

    int         n_pop, n_done, n_abort;
    logic [3:0] last_gnt;
    logic [3:0] gq[$];
    logic [3:0] prev_gnt;
    logic [3:0] s2_exp [5];
    logic [3:0] rq, setm, clrm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_fresh = 1'b0;
        m_left  = 0;
        m_ptr   = 0;
        m_done  = 1'b0;
        m_abort = 1'b0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        logic [N-1:0] sh;
        for (int k = 0; k < int'(N); k++) begin
            sh = r >> ((ptr + k) % N);
            if (sh[0]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] rqv, input logic [N*BW-1:0] bl,
                         input logic emp, input logic [N-1:0] rdy);
        logic [N-1:0]    e_gnt;
        logic [N-1:0]    own_req, own_rdy;
        logic            e_valid, e_inc;
        logic [DW-1:0]   dat;
        logic [N*BW-1:0] blsh;
        int              pick;
        @(negedge r_Clk);
        dat        = DW'($urandom);
        req        = rqv;
        req_Blen   = bl;
        fifo_Empty = emp;
        fifo_Rdata = dat;
        rd_Ready   = rdy;
        #1;
        e_gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        own_req = rqv & e_gnt;
        own_rdy = rdy & e_gnt;
        e_valid = (m_owner >= 0) && !m_fresh && !emp && (own_req != '0);
        e_inc   = e_valid && (own_rdy != '0);
        chk("gnt",   32'(gnt),         32'(e_gnt));
        chk("valid", 32'(rd_Valid),    32'(e_valid));
        chk("inc",   32'(r_Inc),       32'(e_inc));
        chk("done",  32'(burst_Done),  32'(m_done));
        chk("abort", 32'(burst_Abort), 32'(m_abort));
        chk("data",  32'(rd_Data),     32'(dat));
        if (r_Inc) n_pop++;
        if (burst_Done) n_done++;
        if (burst_Done && burst_Abort) n_abort++;
        last_gnt = gnt;
        // advance the model across the coming rising edge
        m_done  = 1'b0;
        m_abort = 1'b0;
        if (m_owner < 0) begin
            pick = rr_pick(rqv, m_ptr);
            if (pick >= 0) begin
                blsh    = bl >> (BW * pick);
                m_owner = pick;
                m_fresh = 1'b1;
                m_left  = 32'(blsh[BW-1:0]) + 1;
            end
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (own_req == '0) begin
            m_done  = 1'b1;
            m_abort = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (e_inc) begin
            m_left--;
            if (m_left == 0) begin
                m_done  = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge r_Clk);
        r_Rst = 1'b0;
        #1;
        chk("rst_gnt",   32'(gnt),        32'(0));
        chk("rst_inc",   32'(r_Inc),      32'(0));
        chk("rst_valid", 32'(rd_Valid),   32'(0));
        chk("rst_done",  32'(burst_Done), 32'(0));
        model_reset();
        repeat (2) @(negedge r_Clk);
        req   = '0;
        r_Rst = 1'b1;
    endtask

    task automatic clr_counts();
        n_pop   = 0;
        n_done  = 0;
        n_abort = 0;
    endtask

    initial begin
        r_Rst      = 1'b0;
        fifo_Empty = 1'b1;
        fifo_Rdata = '0;
        req        = '0;
        req_Blen   = '0;
        rd_Ready   = '0;
        last_gnt   = '0;
        s2_exp     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // single 4-beat burst from requester 0, then pointer moves to 1
        do_reset();
        clr_counts();
        repeat (6) cycle(4'b0001, 8'b00_00_00_11, 1'b0, 4'hf);
        cycle(4'b0000, 8'h00, 1'b0, 4'hf);
        chk("s1_pops",  32'(n_pop),   32'(4));
        chk("s1_done",  32'(n_done),  32'(1));
        chk("s1_abort", 32'(n_abort), 32'(0));
        cycle(4'b0011, 8'h00, 1'b0, 4'hf);
        cycle(4'b0011, 8'h00, 1'b0, 4'hf);
        chk("s1_rr", 32'(last_gnt), 32'(4'b0010));

        // all requesting, single beats: strict rotation
        do_reset();
        gq.delete();
        prev_gnt = '0;
        repeat (16) begin
            cycle(4'b1111, 8'h00, 1'b0, 4'hf);
            if (last_gnt != '0 && prev_gnt == '0) gq.push_back(last_gnt);
            prev_gnt = last_gnt;
        end
        chk("s2_cnt", 32'(gq.size() >= 5), 32'(1));
        for (int i = 0; i < 5; i++) begin
            chk("s2_order", 32'((i < gq.size()) ? gq[i] : 4'h0), 32'(s2_exp[i]));
        end

        // empty FIFO stalls requester 2; blen changed after grant is ignored
        do_reset();
        clr_counts();
        cycle(4'b0100, 8'h30, 1'b1, 4'hf);
        cycle(4'b0100, 8'h00, 1'b1, 4'hf);
        repeat (5) begin
            cycle(4'b0100, 8'h00, 1'b1, 4'hf);
            chk("s3_stall", 32'(r_Inc), 32'(0));
            chk("s3_hold",  32'(gnt),   32'(4'b0100));
        end
        repeat (4) cycle(4'b0100, 8'h00, 1'b0, 4'hf);
        cycle(4'b0000, 8'h00, 1'b0, 4'hf);
        chk("s3_pops",  32'(n_pop),   32'(4));
        chk("s3_done",  32'(n_done),  32'(1));
        chk("s3_abort", 32'(n_abort), 32'(0));

        // requester 1 withdraws after 2 of 4 beats
        do_reset();
        clr_counts();
        repeat (4) cycle(4'b0010, 8'h0c, 1'b0, 4'hf);
        cycle(4'b0000, 8'h0c, 1'b0, 4'hf);
        cycle(4'b0101, 8'h00, 1'b0, 4'hf);
        cycle(4'b0101, 8'h00, 1'b0, 4'hf);
        chk("s4_pops",  32'(n_pop),    32'(2));
        chk("s4_done",  32'(n_done),   32'(1));
        chk("s4_abort", 32'(n_abort),  32'(1));
        chk("s4_next",  32'(last_gnt), 32'(4'b0100));

        // ready toggling during a 2-beat burst
        do_reset();
        clr_counts();
        repeat (2) cycle(4'b0001, 8'h01, 1'b0, 4'h1);
        cycle(4'b0001, 8'h01, 1'b0, 4'h1);
        chk("s5_inc_a", 32'(r_Inc), 32'(1));
        cycle(4'b0001, 8'h01, 1'b0, 4'h0);
        chk("s5_inc_b", 32'(r_Inc), 32'(0));
        cycle(4'b0001, 8'h01, 1'b0, 4'h1);
        chk("s5_inc_c", 32'(r_Inc), 32'(1));
        cycle(4'b0000, 8'h01, 1'b0, 4'h0);
        chk("s5_done", 32'(burst_Done), 32'(1));
        chk("s5_pops", 32'(n_pop),      32'(2));

        // reset in the middle of a burst
        do_reset();
        repeat (3) cycle(4'b0010, 8'h00, 1'b0, 4'hf);
        cycle(4'b0000, 8'h00, 1'b0, 4'hf);
        repeat (3) cycle(4'b0100, 8'h30, 1'b0, 4'hf);
        clr_counts();
        do_reset();
        cycle(4'b1111, 8'h00, 1'b0, 4'hf);
        cycle(4'b1111, 8'h00, 1'b0, 4'hf);
        chk("s6_first",  32'(last_gnt), 32'(4'b0001));
        chk("s6_nodone", 32'(n_done),   32'(0));

        // randomized traffic
        do_reset();
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            setm = 4'($urandom) & 4'($urandom);
            clrm = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
            rq   = (rq | setm) & ~clrm;
            cycle(rq, 8'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom) | 4'($urandom));
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                rq = '0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_sched.md
FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of read requesters sharing the FIFO read port.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: FIFO data width.
REQ-003 SHALL have parameter BLEN_W, default 2: burst-length field width; the encoded value n means n+1 beats (1..4).
REQ-004 SHALL have port r_Clk, input, 1 bit: read-domain clock.
REQ-005 SHALL have port r_Rst, input, 1 bit: read-domain reset, asynchronous, active-low.
REQ-006 SHALL have port fifo_Empty, input, 1 bit: FIFO read-side empty flag.
REQ-007 SHALL have port fifo_Rdata, input, DATA_WIDTH bits: FIFO word at the current read address, valid while fifo_Empty=0.
REQ-008 SHALL have port r_Inc, output, 1 bit: pops one FIFO word on a rising r_Clk edge.
REQ-009 SHALL have port req, input, NUM_REQ bits: per-requester burst request, held high until granted.
REQ-010 SHALL have port req_Blen, input, NUM_REQ*BLEN_W bits: per-requester encoded burst length, sampled at grant.
REQ-011 SHALL have port gnt, output, NUM_REQ bits: one-hot grant, all zero when idle.
REQ-012 SHALL have port rd_Data, output, DATA_WIDTH bits: equals fifo_Rdata.
REQ-013 SHALL have port rd_Valid, output, 1 bit: a beat is offered to the granted requester.
REQ-014 SHALL have port rd_Ready, input, NUM_REQ bits: per-requester beat acceptance.
REQ-015 SHALL have port burst_Done, output, 1 bit: one-cycle pulse at burst end.
REQ-016 SHALL have port burst_Abort, output, 1 bit: qualifies burst_Done; 1 means the requester withdrew early.

Function
REQ-017 SHALL use the three states IDLE, GRANT and XFER.
REQ-018 In IDLE with req nonzero, SHALL select a winner round-robin starting at rr_ptr, register a one-hot gnt, latch the winner's req_Blen into blen and clear beat_cnt, then go to GRANT.
REQ-019 GRANT SHALL last exactly one cycle with rd_Valid=0 and r_Inc=0, then go to XFER.
REQ-020 In XFER, SHALL drive rd_Valid = ~fifo_Empty & req[g], where g is the granted index.
REQ-021 SHALL drive r_Inc = rd_Valid & rd_Ready[g] combinationally, and SHALL drive r_Inc=0 in IDLE and GRANT.
REQ-022 On each cycle with r_Inc=1, SHALL increment beat_cnt, wrapping modulo 2^BLEN_W.
REQ-023 When r_Inc=1 and beat_cnt==blen, SHALL return to IDLE next cycle, pulse burst_Done=1 with burst_Abort=0, set rr_ptr=(g+1) mod NUM_REQ, and clear gnt.
REQ-024 When fifo_Empty=1 in XFER, SHALL stall with no pop and no timeout, and SHALL keep the grant.
REQ-025 When req[g]=0 in XFER, SHALL not pop that cycle, SHALL return to IDLE next cycle, pulse burst_Done=1 with burst_Abort=1, and advance rr_ptr as in REQ-023.
REQ-026 SHALL give req[g]=0 priority over burst completion when both occur in the same cycle; no pop occurs, so the burst ends as an abort.
REQ-027 SHALL ignore changes to req_Blen after the grant.
REQ-028 SHALL keep rd_Valid and r_Inc zero while gnt is zero.
REQ-029 In IDLE with req=0, SHALL hold all state.

Reset
REQ-030 While r_Rst=0, SHALL force state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0, blen=0, burst_Done=0 and burst_Abort=0, so that r_Inc=0 and rd_Valid=0.
REQ-031 On reset assertion mid-burst, SHALL drop r_Inc within the same cycle and produce no burst_Done pulse.
REQ-032 After reset release, SHALL grant no earlier than the first r_Clk edge with req nonzero.

Structure
REQ-033 SHALL place the state encoding (IDLE/GRANT/XFER) and the BLEN_W default in the shared package fifo_rd_sched_pkg.
REQ-034 SHALL implement round-robin selection in the sub-module rr_arbiter, a combinational one-hot picker with inputs req and rr_ptr.

Verification
REQ-035 Verification SHALL cover: req=0001, Blen0=3, FIFO holding 4 words, rd_Ready=1 -> gnt=0001, 4 consecutive r_Inc, burst_Done=1 with burst_Abort=0, rr_ptr=1.
REQ-036 Verification SHALL cover: req=1111 held continuously, all Blen=0 -> grants in the order 0001, 0010, 0100, 1000, 0001, with one beat each.
REQ-037 Verification SHALL cover: grant to requester 2 with Blen=3 and FIFO empty for 5 cycles -> r_Inc=0 and gnt held; then 4 words arrive -> 4 pops, then done.
REQ-038 Verification SHALL cover: granted requester 1 drops req after 2 beats of a 4-beat burst -> no further pops, burst_Done=1 with burst_Abort=1, next grant searches from requester 2.
REQ-039 Verification SHALL cover: rd_Ready toggling 1,0,1,0 during a 2-beat burst -> r_Inc only in ready cycles, done after the 2nd pop.
REQ-040 Verification SHALL cover: r_Rst asserted mid-XFER -> r_Inc=0 immediately, gnt=0, no burst_Done, and first grant after release goes to requester 0.
